// File: rtl/student_fir_out_conditioner_pkg.sv
// Shared types, constants and helpers for the FIR output conditioner.
// - cond_state_e : output FSM states (PRIME waits for the FIFO to fill, RUN streams samples)
// - SAT_MAX/MIN  : 16-bit codec clamp limits
// - round_shift  : arithmetic right shift with round-half-toward-+inf
package student_fir_out_conditioner_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } cond_state_e;

  localparam int unsigned CODEC_DATA_SIZE = 16;

  function automatic logic signed [63:0] sat_max_of(input int unsigned ds);
    logic signed [63:0] one;
    one = 64'sd1;
    sat_max_of = (one <<< (ds - 1)) - one;
  endfunction

  function automatic logic signed [63:0] sat_min_of(input int unsigned ds);
    logic signed [63:0] one;
    one = 64'sd1;
    sat_min_of = -(one <<< (ds - 1));
  endfunction

  localparam logic signed [63:0] SAT_MAX = sat_max_of(CODEC_DATA_SIZE);
  localparam logic signed [63:0] SAT_MIN = sat_min_of(CODEC_DATA_SIZE);

  // x must already be sign-extended; w is the original operand width. Shifts of w or more
  // collapse to the sign, so the rounding bias never reaches into the result.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                     input int unsigned s,
                                                     input int unsigned w);
    logic signed [63:0] bias;
    logic signed [63:0] res;
    if (s == 0) begin
      res = x;
    end else if (s >= w) begin
      res = x[63] ? -64'sd1 : 64'sd0;
    end else begin
      bias = 64'sd1 <<< (s - 1);
      res  = (x + bias) >>> s;
    end
    round_shift = res;
  endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Generic synchronous FIFO with simultaneous push/pop.
// Ports: clk, rst (async, active-high), clr (sync flush), push/wdata, pop/rdata (show-ahead),
//        full, empty, level (occupancy).
// A push while full succeeds only if a pop happens in the same cycle; otherwise it is dropped.
// A pop while empty is ignored.
module student_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/student_fir_out_conditioner.sv
// FIR output conditioner between the parallel FIR and the IIS transmitter.
// Rescales/rounds each FIR result, saturates (or wraps) it to the codec width, buffers it in a
// small FIFO and releases one sample per frame tick. Primes the FIFO before streaming and
// re-primes after an underflow.
// Ports: clk_i, rst_i (async, active-high), data_i/valid_i (FIR result strobe), shift_i,
//        sat_en_i, frame_tick_i, clr_i (sync flush), data_o/valid_o (to transmitter),
//        fifo_level_o, overflow_o (sticky), underflow_cnt_o (saturating).
module student_fir_out_conditioner
  import student_fir_out_conditioner_pkg::*;
#(
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned PRIME_LEVEL       = 2,
  parameter int unsigned SHIFT_W           = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0]    data_i,
  input  logic                            valid_i,
  input  logic [SHIFT_W-1:0]              shift_i,
  input  logic                            sat_en_i,
  input  logic                            frame_tick_i,
  input  logic                            clr_i,
  output logic [DATA_SIZE_FIR_OUT-1:0]    data_o,
  output logic                            valid_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            overflow_o,
  output logic [15:0]                     underflow_cnt_o
);

  localparam int unsigned W  = DATA_SIZE_FIR_OUT;
  localparam int unsigned W1 = W + 1;
  localparam int unsigned DS = DATA_SIZE;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [W:0] LIM_MAX = W1'(sat_max_of(DS));
  localparam logic signed [W:0] LIM_MIN = W1'(sat_min_of(DS));

  // Stage 1: rescale/round in W+1 bits so the rounding bias cannot overflow.
  logic signed [W:0]  x_ext;
  logic signed [63:0] r_full;
  logic signed [W:0]  r1_q;
  logic               v1_q;

  assign x_ext  = {data_i[W-1], data_i};
  assign r_full = round_shift(64'(x_ext), 32'(shift_i), W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      r1_q <= '0;
    end else if (clr_i) begin
      v1_q <= 1'b0;
      r1_q <= '0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) r1_q <= W1'(r_full);
    end
  end

  // Stage 2: clamp or wrap to the codec width, then sign-extend.
  logic [DS-1:0] s2_narrow;
  logic [W-1:0]  s2_ext;
  logic [W-1:0]  d2_q;
  logic          v2_q;

  always_comb begin
    s2_narrow = r1_q[DS-1:0];
    if (sat_en_i) begin
      if (r1_q > LIM_MAX) begin
        s2_narrow = {1'b0, {(DS-1){1'b1}}};
      end else if (r1_q < LIM_MIN) begin
        s2_narrow = {1'b1, {(DS-1){1'b0}}};
      end
    end
  end

  assign s2_ext = {{(W-DS){s2_narrow[DS-1]}}, s2_narrow};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2_q <= 1'b0;
      d2_q <= '0;
    end else if (clr_i) begin
      v2_q <= 1'b0;
      d2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) d2_q <= s2_ext;
    end
  end

  // Sample FIFO, written the cycle after stage 2.
  logic [W-1:0]  fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0] fifo_level;

  student_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (clr_i),
    .push  (v2_q),
    .wdata (d2_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Output FSM. The pop decision uses the FIFO state before this cycle's push, so a tick that
  // coincides with the first push into an empty FIFO is an underflow.
  cond_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic [15:0]  ucnt_q, ucnt_d;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    data_d   = data_q;
    valid_d  = frame_tick_i;
    ucnt_d   = ucnt_q;
    case (state_q)
      PRIME: begin
        if (frame_tick_i) data_d = '0;
        if (fifo_level >= LW'(PRIME_LEVEL)) state_d = RUN;
      end
      RUN: begin
        if (frame_tick_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
          end else begin
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            state_d = PRIME;
          end
        end
      end
      default: state_d = PRIME;
    endcase
    ovf_d = ovf_q | (v2_q & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PRIME;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ucnt_q  <= '0;
    end else if (clr_i) begin
      state_q <= PRIME;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign fifo_level_o    = fifo_level;
  assign overflow_o      = ovf_q;
  assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_student_fir_out_conditioner.sv
module tb_student_fir_out_conditioner;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic [4:0]  shift_i;
  logic        sat_en_i;
  logic        frame_tick_i;
  logic        clr_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic [2:0]  fifo_level_o;
  logic        overflow_o;
  logic [15:0] underflow_cnt_o;

  always #5 clk = ~clk;

  student_fir_out_conditioner dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .shift_i         (shift_i),
    .sat_en_i        (sat_en_i),
    .frame_tick_i    (frame_tick_i),
    .clr_i           (clr_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .fifo_level_o    (fifo_level_o),
    .overflow_o      (overflow_o),
    .underflow_cnt_o (underflow_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];   // expected data_o per valid_o pulse
  logic [31:0] m_fifo[$];  // reference FIFO contents
  bit          m_run;
  bit          m_ovf;
  int          m_ucnt;
  logic [31:0] m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent reference of the conditioning arithmetic.
  function automatic logic [31:0] model_cond(input logic [31:0] x, input int s, input bit sat);
    longint xv;
    longint r;
    longint c;
    xv = longint'($signed(x));
    if (s == 0) r = xv;
    else if (s >= 32) r = (xv < 0) ? -64'sd1 : 64'sd0;
    else r = (xv + (longint'(1) << (s - 1))) >>> s;
    if (sat) begin
      c = r;
      if (c > 32767) c = 32767;
      if (c < -32768) c = -32768;
    end else begin
      c = r & 64'hFFFF;
      if (c >= 32768) c = c - 65536;
    end
    return c[31:0];
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_run  = 1'b0;
    m_ovf  = 1'b0;
    m_ucnt = 0;
    m_last = 32'h0;
  endtask

  task automatic model_push(input logic [31:0] v);
    if (m_fifo.size() < 4) m_fifo.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic model_settle();
    if (!m_run && m_fifo.size() >= 2) m_run = 1'b1;
  endtask

  task automatic model_tick();
    if (!m_run) begin
      m_last = 32'h0;
    end else if (m_fifo.size() > 0) begin
      m_last = m_fifo.pop_front();
    end else begin
      if (m_ucnt < 65535) m_ucnt++;
      m_run = 1'b0;
    end
    exp_q.push_back(m_last);
  endtask

  task automatic push_sample(input logic [31:0] x, input logic [31:0] exp);
    @(negedge clk);
    data_i  = x;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = $urandom;
    model_push(exp);
    repeat (3) @(negedge clk);
    model_settle();
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick_i = 1'b1;
    model_settle();
    model_tick();
    @(negedge clk);
    frame_tick_i = 1'b0;
    @(negedge clk);
    model_settle();
  endtask

  // Sample reaches the FIFO in the same cycle the tick is sampled.
  task automatic push_tick(input logic [31:0] x, input logic [31:0] exp);
    @(negedge clk);
    data_i  = x;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    frame_tick_i = 1'b1;
    model_tick();
    model_push(exp);
    @(negedge clk);
    frame_tick_i = 1'b0;
    repeat (3) @(negedge clk);
    model_settle();
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".level"}, 32'(fifo_level_o), 32'(m_fifo.size()));
    check_eq({tag, ".overflow"}, 32'(overflow_o), 32'(m_ovf));
    check_eq({tag, ".underflow_cnt"}, 32'(underflow_cnt_o), 32'(m_ucnt));
  endtask

  // Scoreboard: every valid_o pulse consumes one expectation.
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) check_eq("spurious_valid_o", 32'(valid_o), 32'h0);
      else check_eq("data_o", data_o, exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] x;
    int          s;
    bit          sat;

    rst_i = 1'b1;
    data_i = '0;
    valid_i = 1'b0;
    shift_i = '0;
    sat_en_i = 1'b1;
    frame_tick_i = 1'b0;
    clr_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset.data_o", data_o, 32'h0);
    check_eq("reset.valid_o", 32'(valid_o), 32'h0);
    check_status("reset");
    rst_i = 1'b0;

    // Priming: one sample is not enough, ticks give zeros.
    shift_i = 5'd0;
    push_sample(32'h0000_0100, 32'h0000_0100);
    check_status("prime1");
    repeat (3) tick();
    check_status("prime_ticks");
    push_sample(32'hFFFF_FF00, 32'hFFFF_FF00);
    tick();

    // Rounding half toward +inf.
    shift_i = 5'd4;
    push_sample(32'h0000_0018, 32'h0000_0002);
    push_sample(32'hFFFF_FFE8, 32'hFFFF_FFFF);
    repeat (3) tick();
    check_status("drained");

    // Underflow holds last value, then PRIME outputs zero.
    tick();
    check_status("underflow");
    tick();

    // Saturation / wrap.
    shift_i  = 5'd0;
    sat_en_i = 1'b1;
    push_sample(32'h0001_2345, 32'h0000_7FFF);
    sat_en_i = 1'b0;
    push_sample(32'h0001_2345, 32'h0000_2345);
    sat_en_i = 1'b1;
    push_sample(32'hFFFF_0000, 32'hFFFF_8000);
    push_sample(32'h0000_0777, 32'h0000_0777);
    check_status("full");

    // Push and pop in the same cycle at full.
    push_tick(32'h0000_0888, 32'h0000_0888);
    check_status("push_pop_full");

    // Overflow drops the new sample.
    push_sample(32'h0000_0999, 32'h0000_0999);
    check_status("overflow");
    repeat (4) tick();
    tick();
    check_status("overflow_drain");

    // Synchronous clear with a sample in flight.
    @(negedge clk);
    data_i  = 32'h0000_0555;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    clr_i   = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_status("clr");
    tick();

    // Randomised traffic through the reference model.
    for (int i = 0; i < 8; i++) begin
      s   = int'($urandom_range(0, 31));
      sat = 1'($urandom_range(0, 1));
      x   = $urandom;
      shift_i  = 5'(s);
      sat_en_i = sat;
      push_sample(x, model_cond(x, s, sat));
      if (i % 2 == 1) tick();
    end
    repeat (6) tick();
    check_status("random");

    // Asynchronous reset with a sample in the pipeline.
    @(negedge clk);
    data_i  = 32'h0000_1234;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check_status("reset_mid");
    check_eq("reset_mid.data_o", data_o, 32'h0);
    tick();

    repeat (4) @(negedge clk);
    check_eq("pending_outputs", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/student_fir_out_conditioner.md
Name: student_fir_out_conditioner

Overview:
- Sits between the parallel FIR output (32-bit accumulator, one valid strobe per result) and the IIS handler's transmit input (Data_I / valid_strobe_I).
- Rescales and rounds each FIR result, and saturates it to the 16-bit codec range.
- Buffers results in a small FIFO and releases exactly one sample per audio frame tick.
- Absorbs FIR latency jitter and re-primes after underflow so the DAC never sees a torn sample stream.

Parameters:
- DATA_SIZE_FIR_OUT, 32: width of FIR result input and of data_o.
- DATA_SIZE, 16: codec sample width; saturation range.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, ≥2.
- PRIME_LEVEL, 2: FIFO level required before output starts; 1..FIFO_DEPTH.
- SHIFT_W, 5: width of shift_i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- data_i  in  DATA_SIZE_FIR_OUT  signed FIR result
- valid_i  in  1  one-cycle strobe; data_i is valid when high
- shift_i  in  SHIFT_W  arithmetic right-shift amount (quasi-static)
- sat_en_i  in  1  1 = saturate to DATA_SIZE, 0 = truncate (wrap)
- frame_tick_i  in  1  one-cycle strobe once per sample period (LRCLK rate)
- clr_i  in  1  synchronous clear: flush FIFO, reset counters/flags, go to PRIME
- data_o  out  DATA_SIZE_FIR_OUT  conditioned sample, sign-extended DATA_SIZE value
- valid_o  out  1  one-cycle strobe to transmitter
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow_o  out  1  sticky: a sample was dropped because the FIFO was full
- underflow_cnt_o  out  16  saturating count of underflow events

Behaviour:
- Reset values: all outputs 0, FIFO empty, state PRIME, pipeline valids 0.
- clr_i acts the same as reset but synchronously. It has priority over push and pop in the same cycle.
- Stage 1 (registered on valid_i), computed in DATA_SIZE_FIR_OUT+1 bits:
  - s = shift_i, r = (x + (1 << (s-1))) >>> s, rounding half toward +inf.
  - s = 0 passes x unchanged.
  - s ≥ DATA_SIZE_FIR_OUT yields sign fill (0 or -1).
- Stage 2 (registered):
  - sat_en_i = 1: clamp r to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - sat_en_i = 0: take r[DATA_SIZE-1:0].
  - Result is sign-extended to DATA_SIZE_FIR_OUT.
- Push into the FIFO on the cycle after stage 2. Latency from valid_i to FIFO entry visible in fifo_level_o is 3 cycles.
- Back-to-back valid_i is accepted every cycle; the pipeline never stalls.
- Push while full (and no pop that cycle): drop the new sample, set overflow_o. Stored data is unchanged.
- Push and pop in the same cycle: both succeed, including at full and at empty+1. The level is unchanged.
- FSM, states PRIME and RUN:
  - PRIME: frame_tick_i produces valid_o = 1 with data_o = 0. No pop, no underflow count. Go to RUN when fifo_level_o ≥ PRIME_LEVEL, evaluated each cycle.
  - RUN, frame_tick_i with FIFO non-empty: pop the head, register it to data_o, pulse valid_o on the next cycle.
  - RUN, frame_tick_i with FIFO empty: underflow. valid_o pulses with data_o holding the last value. underflow_cnt_o increments, saturating at 0xFFFF. Go to PRIME.
- valid_o is exactly one cycle, one cycle after frame_tick_i, in every state. data_o is stable between pulses.
- frame_tick_i coinciding with a push into an empty FIFO in RUN counts as underflow: the pop decision uses the pre-push level.
- Reset mid-stream: asynchronous clear of everything. In-flight pipeline samples are discarded.

Decomposition:
- Package student_fir_out_conditioner_pkg holds:
  - typedef cond_state_e {PRIME, RUN};
  - SAT_MAX/SAT_MIN constants derived from DATA_SIZE;
  - function round_shift().
- One sub-module: student_sync_fifo, a generic synchronous FIFO.
  - Parameters: width, depth.
  - Ports: push, pop, clr, full, empty, level.
  - Simultaneous push/pop supported.

Test Plan:
- Rounding: shift_i=4, sat_en_i=1, data_i 0x00000018 -> 0x00000002; data_i 0xFFFFFFE8 (-24) -> 0xFFFFFFFF (-1).
- Saturation: shift_i=0, data_i 0x00012345, sat_en=1 -> 0x00007FFF; sat_en=0 -> 0x00002345; data_i 0xFFFF0000, sat_en=1 -> 0xFFFF8000.
- Priming: push 1 sample, 3 ticks -> three valid_o with data 0, underflow_cnt 0. Push a 2nd sample -> RUN; next tick outputs the 1st sample.
- Overflow: 5 pushes with no ticks (depth 4) -> level 4, overflow_o=1. Subsequent 4 ticks output samples 1–4 in order; the 5th is lost.
- Underflow: in RUN, drain the FIFO, then tick -> valid_o with data_o = last sample, underflow_cnt 1, state PRIME. Next tick outputs 0.
- Simultaneous/clear: at full, push+tick in the same cycle -> level stays 4, no overflow. clr_i with pending push -> level 0, counters 0, PRIME. rst_i asserted mid-pipeline -> no output, no push after release.
